// File: rtl/mul_three_sgn_pkg.sv
// mul_three_sgn_pkg: shared state encoding and default widths for the product accumulator
package mul_three_sgn_pkg;
  localparam int BW_D = 8;
  localparam int ACC_W_D = BW_D + 4;
  localparam int N_D = 4;
  typedef enum logic {ACCUM, HOLD} state_t;
endpackage

// File: rtl/sat_add_sgn.sv
// sat_add_sgn: signed a + sext(b) at ACC_W+1 bits, clamped to ACC_W; ports a, b in, y, clamp out
module sat_add_sgn #(
  parameter int BW = 8,
  parameter int ACC_W = 12
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [BW-1:0]    b,
  output logic signed [ACC_W-1:0] y,
  output logic                    clamp
);
  logic signed [ACC_W:0] s;
  always_comb begin
    s = {a[ACC_W-1], a} + {{(ACC_W+1-BW){b[BW-1]}}, b};
    clamp = s[ACC_W] != s[ACC_W-1];
    y = clamp ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
  end
endmodule

// File: rtl/prod_accum_sgn.sv
// prod_accum_sgn: saturating frame accumulator; in: clk, rst, in_valid, product, in_last, out_ready; out: in_ready, out_valid, sum, cnt, ovf
module prod_accum_sgn import mul_three_sgn_pkg::*; #(
  parameter int BW = BW_D,
  parameter int ACC_W = ACC_W_D,
  parameter int N = N_D,
  localparam int CW = $clog2(N+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [BW-1:0]    product,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] sum,
  output logic [CW-1:0]           cnt,
  output logic                    ovf
);
  state_t state;
  logic live;
  logic signed [ACC_W-1:0] nxt;
  logic clamp;
  logic in_fire, out_fire, close;
  sat_add_sgn #(.BW(BW), .ACC_W(ACC_W)) u_add (.a(sum), .b(product), .y(nxt), .clamp(clamp));
  // live holds in_ready low while rst is asserted and until the first edge after release
  always_comb begin
    in_ready = live && state == ACCUM;
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    close = in_last || cnt == CW'(N-1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      live <= 1'b0;
      sum <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      live <= 1'b1;
      if (in_fire) begin
        sum <= nxt;
        cnt <= cnt + 1'b1;
        ovf <= ovf | clamp;
        if (close) begin
          state <= HOLD;
          out_valid <= 1'b1;
        end
      end else if (out_fire) begin
        state <= ACCUM;
        out_valid <= 1'b0;
        sum <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_prod_accum_sgn.sv
// tb_prod_accum_sgn: directed checks of two accumulator instances (ACC_W=12 and ACC_W=8)
module tb_prod_accum_sgn;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic signed [7:0] product = 0;
  logic rdy_a, ov_a, of_a, rdy_b, ov_b, of_b;
  logic signed [11:0] sum_a;
  logic signed [7:0] sum_b;
  logic [2:0] cnt_a, cnt_b;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  prod_accum_sgn #(.BW(8), .ACC_W(12), .N(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .product(product),
    .in_last(in_last), .out_valid(ov_a), .out_ready(out_ready), .sum(sum_a), .cnt(cnt_a), .ovf(of_a));
  prod_accum_sgn #(.BW(8), .ACC_W(8), .N(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .product(product),
    .in_last(in_last), .out_valid(ov_b), .out_ready(out_ready), .sum(sum_b), .cnt(cnt_b), .ovf(of_b));
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic beat(input int p, input logic last);
    in_valid = 1;
    product = 8'(p);
    in_last = last;
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic consume();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  initial begin
    #3;
    chk("rst_in_ready", int'(rdy_a), 0);
    chk("rst_out_valid", int'(ov_a), 0);
    chk("rst_sum", int'(sum_a), 0);
    #9 rst = 0;
    @(posedge clk); #1;
    chk("ready_after_rst", int'(rdy_a), 1);
    beat(10, 0); beat(-3, 0); beat(127, 0);
    chk("a_not_done_3", int'(ov_a), 0);
    beat(-128, 0);
    chk("a_valid", int'(ov_a), 1);
    chk("a_sum", int'(sum_a), 6);
    chk("a_cnt", int'(cnt_a), 4);
    chk("a_ovf", int'(of_a), 0);
    chk("a_hold_ready", int'(rdy_a), 0);
    consume();
    chk("a_cleared_valid", int'(ov_a), 0);
    chk("a_cleared_sum", int'(sum_a), 0);
    chk("a_cleared_cnt", int'(cnt_a), 0);
    chk("a_ready_again", int'(rdy_a), 1);
    beat(100, 0); beat(100, 0);
    chk("b_clamp_hi", int'(sum_b), 127);
    beat(-50, 0); beat(0, 0);
    chk("b_sum_77", int'(sum_b), 77);
    chk("b_ovf_77", int'(of_b), 1);
    chk("b_valid_77", int'(ov_b), 1);
    consume();
    chk("b_ovf_cleared", int'(of_b), 0);
    beat(-128, 0); beat(-128, 0);
    chk("b_clamp_lo", int'(sum_b), -128);
    beat(100, 0); beat(0, 0);
    chk("b_sum_m28", int'(sum_b), -28);
    chk("b_ovf_m28", int'(of_b), 1);
    consume();
    beat(5, 1);
    chk("last_valid", int'(ov_a), 1);
    chk("last_sum", int'(sum_a), 5);
    chk("last_cnt", int'(cnt_a), 1);
    chk("last_ovf", int'(of_a), 0);
    in_valid = 1;
    product = 99;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", int'(ov_a), 1);
      chk("hold_sum", int'(sum_a), 5);
      chk("hold_cnt", int'(cnt_a), 1);
      chk("hold_ready", int'(rdy_a), 0);
    end
    in_valid = 0;
    consume();
    beat(2, 1);
    chk("next_sum", int'(sum_a), 2);
    chk("next_cnt", int'(cnt_a), 1);
    consume();
    beat(7, 0); beat(8, 0);
    chk("partial_sum", int'(sum_a), 15);
    rst = 1;
    #2;
    chk("midrst_ready", int'(rdy_a), 0);
    chk("midrst_sum", int'(sum_a), 0);
    chk("midrst_cnt", int'(cnt_a), 0);
    #2 rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_valid", int'(ov_a), 0);
    end
    chk("postrst_ready", int'(rdy_a), 1);
    beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 0);
    chk("ones_valid", int'(ov_a), 1);
    chk("ones_sum", int'(sum_a), 4);
    chk("ones_cnt", int'(cnt_a), 4);
    consume();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prod_accum_sgn.md
PROD_ACCUM_SGN -- requirements
Module: prod_accum_sgn

Interface
REQ-001 Parameter: BW, 8, width of the signed product input from the three-operand signed multiplier stage.
REQ-002 Parameter: ACC_W, BW+4, signed accumulator/result width; ACC_W >= BW SHALL hold.
REQ-003 Parameter: N, 4, products per frame; N >= 1.
REQ-004 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: in_valid  input  1  product beat offered.
REQ-007 Port: in_ready  output  1  block can accept a beat.
REQ-008 Port: product  input  BW signed  product from the upstream multiplier.
REQ-009 Port: in_last  input  1  beat closes the frame early.
REQ-010 Port: out_valid  output  1  frame result available.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: sum  output  ACC_W signed  saturated frame sum.
REQ-013 Port: cnt  output  $clog2(N+1)  beats in the frame.
REQ-014 Port: ovf  output  1  saturation occurred in the frame (sticky per frame).

Function
REQ-015 FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 Input beat transfers iff in_valid && in_ready; output transfers iff out_valid && out_ready.
REQ-017 On each input transfer: acc <= sat(acc + sext(product)), computed at ACC_W+1 bits, clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-018 ovf SHALL set when any clamp occurs in the frame and stay set until the frame is consumed.
REQ-019 cnt SHALL increment by one per input transfer.
REQ-020 Frame closes on the transfer where in_last=1 or cnt reaches N-1 before increment; FSM moves ACCUM->HOLD.
REQ-021 Latency: out_valid SHALL assert the cycle after the closing input transfer, with sum/cnt/ovf including that beat.
REQ-022 In HOLD, sum/cnt/ovf SHALL remain stable while out_ready=0 (unlimited backpressure).
REQ-023 On output transfer: HOLD->ACCUM; acc, cnt, ovf cleared to 0 the next cycle.
REQ-024 in_valid in HOLD SHALL be ignored; product/in_last don't-care when not transferring.
REQ-025 Saturation is absorbing-free: a later opposite-sign beat SHALL move acc off the clamp.

Reset
REQ-026 rst asserted SHALL immediately force state ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=0.
REQ-027 in_ready SHALL be 1 from the first rising clk edge after rst deasserts.
REQ-028 rst mid-frame or during HOLD SHALL discard the partial/pending result; no output beat follows.

Structure
REQ-029 State enum (ACCUM, HOLD) and default BW/ACC_W/N constants SHALL live in shared package mul_three_sgn_pkg.
REQ-030 One sub-module sat_add_sgn (signed ACC_W+1-bit add, clamp, overflow flag) SHALL implement REQ-017/018.
REQ-031 All outputs SHALL be driven from registers except in_ready (decoded from state register).

Verification
REQ-032 BW=8, ACC_W=12, N=4: products 10,-3,127,-128 -> sum=6, cnt=4, ovf=0, out_valid one cycle after fourth beat.
REQ-033 ACC_W=8, N=4: products 100,100,-50,0 -> sum=77 (127 clamp then -50), ovf=1.
REQ-034 product=5 with in_last=1 as first beat -> sum=5, cnt=1, ovf=0.
REQ-035 Frame complete, out_ready=0 for 3 cycles then 1 -> outputs stable, in_ready=0 during hold, next frame starts with acc=0.
REQ-036 rst pulse after two beats (7,8) -> out_valid stays 0; next frame 1,1,1,1 -> sum=4.
REQ-037 ACC_W=8: products -128,-128,100,0 -> sum=-28 (clamp -128 then +100), ovf=1.
